// File: rtl/mem_arb_pkg.sv
// Shared types for the I/D memory arbiter.
// FSM encoding and default bus widths.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 28;
  localparam int DEF_LINE_W = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_I  = 2'd1,
    BUSY_D  = 2'd2,
    RELEASE = 2'd3
  } state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache and memory line ports seen by the arbiter.
// slave = arbiter side, master = caches/memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int LINE_W = 128
);

  logic              i_mem_read;
  logic [ADDR_W-1:0] i_mem_addr;
  logic [LINE_W-1:0] i_mem_rdata;
  logic              i_mem_ready;

  logic              d_mem_read;
  logic              d_mem_write;
  logic [ADDR_W-1:0] d_mem_addr;
  logic [LINE_W-1:0] d_mem_wdata;
  logic [LINE_W-1:0] d_mem_rdata;
  logic              d_mem_ready;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ready;

  logic              grant_d;
  logic              tmo_err;

  modport slave (
    input  i_mem_read, i_mem_addr,
    output i_mem_rdata, i_mem_ready,
    input  d_mem_read, d_mem_write,
    input  d_mem_addr, d_mem_wdata,
    output d_mem_rdata, d_mem_ready,
    output mem_read, mem_write,
    output mem_addr, mem_wdata,
    input  mem_rdata, mem_ready,
    output grant_d, tmo_err
  );

  modport master (
    output i_mem_read, i_mem_addr,
    input  i_mem_rdata, i_mem_ready,
    output d_mem_read, d_mem_write,
    output d_mem_addr, d_mem_wdata,
    input  d_mem_rdata, d_mem_ready,
    input  mem_read, mem_write,
    input  mem_addr, mem_wdata,
    output mem_rdata, mem_ready,
    input  grant_d, tmo_err
  );

endinterface

// File: rtl/arb_rr2.sv
// Two-way round-robin picker.
// On a tie the side not granted last wins.
module arb_rr2 (
  input  logic req_i,
  input  logic req_d,
  input  logic last_d,
  output logic pick_d
);

  assign pick_d = req_d & (~req_i | ~last_d);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory line port between I- and D-cache.
// One transaction in flight, fields latched at grant.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINE_W = DEF_LINE_W,
  parameter int TMO_W  = 16
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam logic [TMO_W-1:0] ONE = 1;

  state_t           state;
  logic [TMO_W-1:0] cnt;
  logic [TMO_W-1:0] cnt_nxt;
  logic             req_i;
  logic             req_d;
  logic             pick_d;

  assign req_i = bus.i_mem_read;
  assign req_d = bus.d_mem_read
               | bus.d_mem_write;

  // Saturating wait count
  assign cnt_nxt = (&cnt) ? cnt : cnt + ONE;

  arb_rr2 u_rr (
    .req_i  (req_i),
    .req_d  (req_d),
    .last_d (bus.grant_d),
    .pick_d (pick_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      bus.mem_read    <= 1'b0;
      bus.mem_write   <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wdata   <= '0;
      bus.i_mem_rdata <= '0;
      bus.i_mem_ready <= 1'b0;
      bus.d_mem_rdata <= '0;
      bus.d_mem_ready <= 1'b0;
      bus.grant_d     <= 1'b0;
      bus.tmo_err     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_i | req_d) begin
            bus.grant_d <= pick_d;
            cnt         <= '0;
            if (pick_d) begin
              // Write wins over a simultaneous read
              bus.mem_addr  <= bus.d_mem_addr;
              bus.mem_wdata <= bus.d_mem_wdata;
              bus.mem_write <= bus.d_mem_write;
              bus.mem_read  <= ~bus.d_mem_write;
              state         <= BUSY_D;
            end else begin
              bus.mem_addr  <= bus.i_mem_addr;
              bus.mem_write <= 1'b0;
              bus.mem_read  <= 1'b1;
              state         <= BUSY_I;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          if (bus.mem_ready) begin
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            cnt           <= '0;
            state         <= RELEASE;
            if (state == BUSY_I) begin
              bus.i_mem_ready <= 1'b1;
              if (bus.mem_read)
                bus.i_mem_rdata <= bus.mem_rdata;
            end else begin
              bus.d_mem_ready <= 1'b1;
              if (bus.mem_read)
                bus.d_mem_rdata <= bus.mem_rdata;
            end
          end else begin
            cnt <= cnt_nxt;
            if (&cnt_nxt)
              bus.tmo_err <= 1'b1;
          end
        end
        RELEASE: begin
          bus.i_mem_ready <= 1'b0;
          bus.d_mem_ready <= 1'b0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter.
// Built with TMO_W=4 so the timeout is reachable.
module tb_mem_arbiter;

  localparam int AW = 28;
  localparam int LW = 128;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vec = 0;
  int   errs = 0;

  mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

  mem_arbiter #(
    .ADDR_W (AW),
    .LINE_W (LW),
    .TMO_W  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [417:0] outs;
  assign outs = {bus.i_mem_rdata, bus.i_mem_ready,
                 bus.d_mem_rdata, bus.d_mem_ready,
                 bus.mem_read, bus.mem_write,
                 bus.mem_addr, bus.mem_wdata,
                 bus.grant_d, bus.tmo_err};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.i_mem_read  = 1'b0;
    bus.i_mem_addr  = '0;
    bus.d_mem_read  = 1'b0;
    bus.d_mem_write = 1'b0;
    bus.d_mem_addr  = '0;
    bus.d_mem_wdata = '0;
    bus.mem_rdata   = '0;
    bus.mem_ready   = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    vec++;
    if (outs !== '0) begin
      errs++;
      $display("FAIL reset_outs got %h exp 0", outs);
    end
  endtask

  task automatic test_i_read();
    logic [LW-1:0] a5;
    a5 = {16{8'hA5}};
    bus.i_mem_read = 1'b1;
    bus.i_mem_addr = 28'h0000010;
    tick();
    vec++;
    if ({bus.mem_read, bus.mem_write,
         bus.mem_addr, bus.grant_d}
        !== {1'b1, 1'b0, 28'h0000010, 1'b0}) begin
      errs++;
      $display("FAIL i_grant got %b %b %h %b",
               bus.mem_read, bus.mem_write,
               bus.mem_addr, bus.grant_d);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      vec++;
      if ({bus.mem_read, bus.i_mem_ready} !== 2'b10) begin
        errs++;
        $display("FAIL i_wait%0d got %b exp 10", k,
                 {bus.mem_read, bus.i_mem_ready});
      end
    end
    bus.mem_rdata = a5;
    bus.mem_ready = 1'b1;
    tick();
    bus.i_mem_read = 1'b0;
    bus.mem_ready  = 1'b0;
    bus.mem_rdata  = '0;
    vec++;
    if ({bus.i_mem_ready, bus.mem_read} !== 2'b10 ||
        bus.i_mem_rdata !== a5) begin
      errs++;
      $display("FAIL i_done got %b %b %h exp 1 0 %h",
               bus.i_mem_ready, bus.mem_read,
               bus.i_mem_rdata, a5);
    end
    vec++;
    if (bus.d_mem_ready !== 1'b0 ||
        bus.d_mem_rdata !== '0) begin
      errs++;
      $display("FAIL i_d_untouched got %b %h exp 0 0",
               bus.d_mem_ready, bus.d_mem_rdata);
    end
    tick();
    vec++;
    if (bus.i_mem_ready !== 1'b0 ||
        bus.i_mem_rdata !== a5) begin
      errs++;
      $display("FAIL i_pulse got %b %h exp 0 %h",
               bus.i_mem_ready, bus.i_mem_rdata, a5);
    end
  endtask

  task automatic test_tie();
    do_reset();
    bus.i_mem_read = 1'b1;
    bus.i_mem_addr = 28'h0000100;
    bus.d_mem_read = 1'b1;
    bus.d_mem_addr = 28'h0000200;
    tick();
    vec++;
    if ({bus.grant_d, bus.mem_read, bus.mem_addr}
        !== {1'b1, 1'b1, 28'h0000200}) begin
      errs++;
      $display("FAIL tie_d_first got %b %b %h exp 1 1 200",
               bus.grant_d, bus.mem_read, bus.mem_addr);
    end
    bus.mem_rdata = {4{32'h1111_2222}};
    bus.mem_ready = 1'b1;
    tick();
    bus.d_mem_read = 1'b0;
    bus.mem_ready  = 1'b0;
    vec++;
    if ({bus.d_mem_ready, bus.i_mem_ready} !== 2'b10 ||
        bus.d_mem_rdata !== {4{32'h1111_2222}}) begin
      errs++;
      $display("FAIL tie_d_done got %b %b %h",
               bus.d_mem_ready, bus.i_mem_ready,
               bus.d_mem_rdata);
    end
    tick();
    vec++;
    if (bus.mem_read !== 1'b0) begin
      errs++;
      $display("FAIL tie_release got %b exp 0",
               bus.mem_read);
    end
    tick();
    vec++;
    if ({bus.grant_d, bus.mem_read, bus.mem_addr}
        !== {1'b0, 1'b1, 28'h0000100}) begin
      errs++;
      $display("FAIL tie_i_second got %b %b %h exp 0 1 100",
               bus.grant_d, bus.mem_read, bus.mem_addr);
    end
    bus.mem_rdata = {4{32'h3333_4444}};
    bus.mem_ready = 1'b1;
    tick();
    bus.i_mem_read = 1'b0;
    bus.mem_ready  = 1'b0;
    vec++;
    if (bus.i_mem_ready !== 1'b1 ||
        bus.i_mem_rdata !== {4{32'h3333_4444}} ||
        bus.d_mem_rdata !== {4{32'h1111_2222}}) begin
      errs++;
      $display("FAIL tie_i_done got %b %h %h",
               bus.i_mem_ready, bus.i_mem_rdata,
               bus.d_mem_rdata);
    end
    tick();
  endtask

  task automatic test_d_write();
    logic [LW-1:0] wd;
    logic [LW-1:0] old;
    wd  = 128'h0123456789ABCDEF0123456789ABCDEF;
    old = {4{32'h1111_2222}};
    bus.d_mem_write = 1'b1;
    bus.d_mem_addr  = 28'h1234567;
    bus.d_mem_wdata = wd;
    tick();
    bus.d_mem_addr  = 28'h7654321;
    bus.d_mem_wdata = ~wd;
    bus.d_mem_read  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      vec++;
      if ({bus.mem_write, bus.mem_read, bus.grant_d,
           bus.mem_addr} !== {3'b101, 28'h1234567} ||
          bus.mem_wdata !== wd) begin
        errs++;
        $display("FAIL dw_stable%0d got %b%b %h %h", k,
                 bus.mem_write, bus.mem_read,
                 bus.mem_addr, bus.mem_wdata);
      end
      bus.d_mem_write = ~bus.d_mem_write;
      tick();
    end
    bus.d_mem_write = 1'b1;
    bus.mem_rdata   = {4{32'hDEAD_BEEF}};
    bus.mem_ready   = 1'b1;
    tick();
    bus.d_mem_write = 1'b0;
    bus.d_mem_read  = 1'b0;
    bus.mem_ready   = 1'b0;
    vec++;
    if ({bus.d_mem_ready, bus.mem_write} !== 2'b10 ||
        bus.d_mem_rdata !== old) begin
      errs++;
      $display("FAIL dw_done got %b %b %h exp 1 0 %h",
               bus.d_mem_ready, bus.mem_write,
               bus.d_mem_rdata, old);
    end
    tick();
    vec++;
    if (bus.d_mem_ready !== 1'b0) begin
      errs++;
      $display("FAIL dw_pulse got %b exp 0",
               bus.d_mem_ready);
    end
  endtask

  task automatic test_spurious();
    logic [LW-1:0] di;
    logic [LW-1:0] ii;
    di = bus.d_mem_rdata;
    ii = bus.i_mem_rdata;
    bus.mem_rdata = {4{32'hBAD0_BAD0}};
    bus.mem_ready = 1'b1;
    tick();
    tick();
    vec++;
    if ({bus.i_mem_ready, bus.d_mem_ready,
         bus.mem_read, bus.mem_write} !== 4'b0 ||
        bus.d_mem_rdata !== di ||
        bus.i_mem_rdata !== ii) begin
      errs++;
      $display("FAIL idle_spurious got %b%b %h %h",
               bus.i_mem_ready, bus.d_mem_ready,
               bus.i_mem_rdata, bus.d_mem_rdata);
    end
    bus.mem_ready   = 1'b0;
    bus.d_mem_write = 1'b1;
    bus.d_mem_addr  = 28'h00000AA;
    tick();
    bus.mem_ready = 1'b1;
    tick();
    bus.d_mem_write = 1'b0;
    bus.d_mem_read  = 1'b1;
    bus.d_mem_addr  = 28'h00000BB;
    tick();
    bus.mem_ready = 1'b0;
    vec++;
    if ({bus.d_mem_ready, bus.mem_read,
         bus.mem_write} !== 3'b000 ||
        bus.d_mem_rdata !== di) begin
      errs++;
      $display("FAIL rel_spurious got %b%b%b %h",
               bus.d_mem_ready, bus.mem_read,
               bus.mem_write, bus.d_mem_rdata);
    end
    tick();
    vec++;
    if ({bus.mem_read, bus.grant_d, bus.mem_addr}
        !== {2'b11, 28'h00000BB}) begin
      errs++;
      $display("FAIL b2b_grant got %b %b %h exp 1 1 bb",
               bus.mem_read, bus.grant_d, bus.mem_addr);
    end
    bus.mem_rdata = {4{32'h5555_6666}};
    bus.mem_ready = 1'b1;
    tick();
    bus.d_mem_read = 1'b0;
    bus.mem_ready  = 1'b0;
    vec++;
    if (bus.d_mem_ready !== 1'b1 ||
        bus.d_mem_rdata !== {4{32'h5555_6666}}) begin
      errs++;
      $display("FAIL b2b_read got %b %h",
               bus.d_mem_ready, bus.d_mem_rdata);
    end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    bus.i_mem_read = 1'b1;
    bus.i_mem_addr = 28'h0000040;
    tick();
    for (int k = 1; k <= 16; k++) begin
      tick();
      vec++;
      if (bus.tmo_err !== (k >= 15)) begin
        errs++;
        $display("FAIL tmo_cnt%0d got %b exp %b", k,
                 bus.tmo_err, (k >= 15));
      end
    end
    bus.mem_rdata = {4{32'h7777_8888}};
    bus.mem_ready = 1'b1;
    tick();
    bus.i_mem_read = 1'b0;
    bus.mem_ready  = 1'b0;
    vec++;
    if ({bus.i_mem_ready, bus.tmo_err} !== 2'b11) begin
      errs++;
      $display("FAIL tmo_done got %b %b exp 1 1",
               bus.i_mem_ready, bus.tmo_err);
    end
    tick();
    tick();
    vec++;
    if (bus.tmo_err !== 1'b1) begin
      errs++;
      $display("FAIL tmo_sticky got %b exp 1",
               bus.tmo_err);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.d_mem_read = 1'b1;
    bus.d_mem_addr = 28'h0000ABC;
    tick();
    tick();
    vec++;
    if ({bus.mem_read, bus.grant_d} !== 2'b11) begin
      errs++;
      $display("FAIL mid_busy got %b %b exp 1 1",
               bus.mem_read, bus.grant_d);
    end
    #2;
    rst = 1'b1;
    #1;
    vec++;
    if (outs !== '0) begin
      errs++;
      $display("FAIL mid_async got %h exp 0", outs);
    end
    #1;
    rst = 1'b0;
    tick();
    vec++;
    if ({bus.mem_read, bus.grant_d, bus.mem_addr}
        !== {2'b11, 28'h0000ABC}) begin
      errs++;
      $display("FAIL mid_restart got %b %b %h",
               bus.mem_read, bus.grant_d, bus.mem_addr);
    end
    bus.mem_ready = 1'b1;
    tick();
    bus.d_mem_read = 1'b0;
    bus.mem_ready  = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_tie();
    test_d_write();
    test_spurious();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vec, errs);
    $finish;
  end

endmodule
